mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between an instruction-fetch port
// and a data port. Data wins contention until the instruction port has lost MAX_WAIT times in a row.
module mem_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req_valid,
   input  logic [31:0] i_addr,
   output logic        i_req_ready,
   output logic        i_rsp_valid,
   output logic [31:0] i_rsp_data,
   input  logic        d_req_valid,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_req_ready,
   output logic        d_rsp_valid,
   output logic [31:0] d_rsp_data,
   output logic [31:0] mem_ra,
   input  logic [31:0] mem_rd,
   output logic        mem_we,
   output logic [31:0] mem_wa,
   output logic [31:0] mem_wd
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          i_rsp_valid_q, i_rsp_valid_d;
   logic          d_rsp_valid_q, d_rsp_valid_d;
   logic [31:0]   i_rsp_data_q, i_rsp_data_d;
   logic [31:0]   d_rsp_data_q, d_rsp_data_d;
   logic          i_gnt, d_gnt;

   // Grant is suppressed while reset is high so nothing can be accepted or written.
   always_comb begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!reset) begin
         i_gnt = i_req_valid && (!d_req_valid || wait_cnt_q == WAIT_MAX);
         d_gnt = d_req_valid && !i_gnt;
      end
   end

   always_comb begin
      mem_ra = 32'h0;
      if (i_gnt)      mem_ra = i_addr;
      else if (d_gnt) mem_ra = d_addr;
   end

   assign i_req_ready = i_gnt;
   assign d_req_ready = d_gnt;
   assign mem_we      = d_gnt && d_we;
   assign mem_wa      = d_addr;
   assign mem_wd      = d_wdata;

   always_comb begin
      wait_cnt_d    = wait_cnt_q;
      i_rsp_valid_d = i_gnt;
      d_rsp_valid_d = d_gnt;
      i_rsp_data_d  = i_rsp_data_q;
      d_rsp_data_d  = d_rsp_data_q;
      if (i_gnt)
         wait_cnt_d = '0;
      else if (i_req_valid && wait_cnt_q != WAIT_MAX)
         wait_cnt_d = wait_cnt_q + 1'b1;
      if (i_gnt)
         i_rsp_data_d = mem_rd;
      // Write acknowledges return zero; the data register holds otherwise.
      if (d_gnt)
         d_rsp_data_d = d_we ? 32'h0 : mem_rd;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_q    <= '0;
         i_rsp_valid_q <= 1'b0;
         d_rsp_valid_q <= 1'b0;
         i_rsp_data_q  <= 32'h0;
         d_rsp_data_q  <= 32'h0;
      end else begin
         wait_cnt_q    <= wait_cnt_d;
         i_rsp_valid_q <= i_rsp_valid_d;
         d_rsp_valid_q <= d_rsp_valid_d;
         i_rsp_data_q  <= i_rsp_data_d;
         d_rsp_data_q  <= d_rsp_data_d;
      end
   end

   assign i_rsp_valid = i_rsp_valid_q;
   assign d_rsp_valid = d_rsp_valid_q;
   assign i_rsp_data  = i_rsp_data_q;
   assign d_rsp_data  = d_rsp_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (shadow memory, loss counter, expected response per port).
module tb_mem_arbiter;
   localparam int MAX_WAIT = 4;

   logic        clk, reset;
   logic        i_req_valid, i_req_ready, i_rsp_valid;
   logic [31:0] i_addr, i_rsp_data;
   logic        d_req_valid, d_we, d_req_ready, d_rsp_valid;
   logic [31:0] d_addr, d_wdata, d_rsp_data;
   logic [31:0] mem_ra, mem_rd, mem_wa, mem_wd;
   logic        mem_we;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .i_req_valid(i_req_valid), .i_addr(i_addr), .i_req_ready(i_req_ready),
      .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
      .d_req_valid(d_req_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
      .mem_ra(mem_ra), .mem_rd(mem_rd), .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory harness driven only by the DUT's memory port.
   logic [31:0] mem [0:255];
   assign mem_rd = mem[mem_ra[9:2]];
   always @(posedge clk) if (mem_we) mem[mem_wa[9:2]] <= mem_wd;

   function automatic logic [31:0] init_word(int k);
      logic [7:0] b;
      b = 8'(k);
      if (k == 64) return 32'hDEADBEEF;
      return {8'hC0, b, ~b, 8'h5A};
   endfunction

   // Reference model state.
   logic [31:0] ref_mem [0:255];
   int          losses;
   logic        m_irv, m_drv;
   logic [31:0] m_ird, m_drd;

   initial for (int k = 0; k < 256; k++) begin
      mem[k] <= init_word(k);
      ref_mem[k] = init_word(k);
   end

   task automatic model_reset();
      losses = 0; m_irv = 1'b0; m_drv = 1'b0; m_ird = 32'h0; m_drd = 32'h0;
   endtask

   // Advance one clock with the current inputs, updating the model as the spec dictates.
   task automatic tick();
      logic ig, dg;
      ig = i_req_valid && (!d_req_valid || losses >= MAX_WAIT);
      dg = d_req_valid && !ig;
      @(posedge clk);
      m_irv = ig;
      m_drv = dg;
      if (ig) begin
         m_ird = ref_mem[i_addr[9:2]];
         losses = 0;
      end else if (i_req_valid && losses < MAX_WAIT) losses++;
      if (dg) begin
         if (d_we) begin
            m_drd = 32'h0;
            ref_mem[d_addr[9:2]] = d_wdata;
         end else m_drd = ref_mem[d_addr[9:2]];
      end
      #1;
   endtask

   task automatic idle_inputs();
      i_req_valid = 0; i_addr = 0; d_req_valid = 0; d_we = 0; d_addr = 0; d_wdata = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      i_req_valid = 1; i_addr = 32'h100; d_req_valid = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h55;
      model_reset();
      #1;
      checks++; if (i_req_ready !== 1'b0) begin errors++; $display("FAIL rst_i_ready got %b want 0", i_req_ready); end
      checks++; if (d_req_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready got %b want 0", d_req_ready); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({i_rsp_valid, d_rsp_valid} !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b want 00", {i_rsp_valid, d_rsp_valid}); end
      checks++; if (i_rsp_data !== 32'h0 || d_rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data got %h/%h want 0/0", i_rsp_data, d_rsp_data); end
      reset = 1'b0;
      d_we = 0;
      #1;
      checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL first_grant got %b want 1", d_req_ready); end
      idle_inputs();
   endtask

   task automatic test_ifetch();
      do_reset();
      i_req_valid = 1; i_addr = 32'h100;
      #1;
      checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL ifetch_ready got %b want 1", i_req_ready); end
      checks++; if (mem_ra !== 32'h100) begin errors++; $display("FAIL ifetch_ra got %h want 00000100", mem_ra); end
      tick();
      i_req_valid = 0;
      checks++; if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ifetch_rsp got %b/%h want 1/deadbeef", i_rsp_valid, i_rsp_data); end
      tick();
      checks++; if (i_rsp_valid !== 1'b0 || i_rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ifetch_hold got %b/%h want 0/deadbeef", i_rsp_valid, i_rsp_data); end
   endtask

   task automatic test_write_read();
      do_reset();
      d_req_valid = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678;
      #1;
      checks++; if (mem_we !== 1'b1 || mem_wa !== 32'h200 || mem_wd !== 32'h12345678) begin errors++; $display("FAIL wr_port got %b/%h/%h want 1/200/12345678", mem_we, mem_wa, mem_wd); end
      tick();
      d_we = 0;
      checks++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h0) begin errors++; $display("FAIL wr_ack got %b/%h want 1/0", d_rsp_valid, d_rsp_data); end
      tick();
      d_req_valid = 0;
      checks++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h12345678) begin errors++; $display("FAIL rd_after_wr got %b/%h want 1/12345678", d_rsp_valid, d_rsp_data); end
      tick();
      checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_idle got %b want 0", d_rsp_valid); end
   endtask

   task automatic test_starvation();
      logic want_i;
      do_reset();
      i_req_valid = 1; i_addr = 32'h100; d_req_valid = 1; d_we = 0; d_addr = 32'h8;
      for (int c = 0; c < 15; c++) begin
         want_i = (c % 5 == 4);
         #1;
         checks++; if (i_req_ready !== want_i || d_req_ready !== !want_i) begin errors++; $display("FAIL starve_c%0d got i%b d%b want i%b d%b", c, i_req_ready, d_req_ready, want_i, !want_i); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_write_grant();
      logic want_d;
      do_reset();
      i_req_valid = 1; i_addr = 32'h104; d_req_valid = 1; d_we = 1; d_addr = 32'h40; d_wdata = $urandom;
      for (int c = 0; c < 10; c++) begin
         want_d = (c % 5 != 4);
         #1;
         checks++; if (mem_we !== want_d || mem_wa !== 32'h40 || i_req_ready !== !want_d) begin errors++; $display("FAIL wgrant_c%0d got we%b wa%h ir%b want we%b wa40 ir%b", c, mem_we, mem_wa, i_req_ready, want_d, !want_d); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      i_req_valid = 1; i_addr = 32'h100;
      tick();
      reset = 1'b1;
      idle_inputs();
      #1;
      checks++; if (i_rsp_valid !== 1'b0 || i_rsp_data !== 32'h0) begin errors++; $display("FAIL rmid_async got %b/%h want 0/0", i_rsp_valid, i_rsp_data); end
      checks++; if (d_rsp_valid !== 1'b0 || d_rsp_data !== 32'h0) begin errors++; $display("FAIL rmid_d got %b/%h want 0/0", d_rsp_valid, d_rsp_data); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_hold got %b want 0", i_rsp_valid); end
      reset = 1'b0;
      model_reset();
      tick();
      checks++; if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_after got %b want 0", i_rsp_valid); end
   endtask

   task automatic test_burst_read();
      do_reset();
      d_req_valid = 1; d_we = 0;
      for (int k = 0; k < 8; k++) begin
         d_addr = 32'(k * 4);
         #1;
         checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL burst_ready_%0d got %b want 1", k, d_req_ready); end
         tick();
         checks++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== init_word(k)) begin errors++; $display("FAIL burst_rsp_%0d got %b/%h want 1/%h", k, d_rsp_valid, d_rsp_data, init_word(k)); end
      end
      d_req_valid = 0;
      tick();
      checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL burst_end got %b want 0", d_rsp_valid); end
   endtask

   task automatic test_random();
      logic ig, dg;
      logic [31:0] exp_ra;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         i_req_valid = ($urandom_range(0, 3) != 0);
         d_req_valid = ($urandom_range(0, 3) != 0);
         d_we        = $urandom_range(0, 1);
         i_addr      = $urandom_range(0, 1023);
         d_addr      = $urandom_range(0, 1023);
         d_wdata     = $urandom;
         #1;
         ig = i_req_valid && (!d_req_valid || losses >= MAX_WAIT);
         dg = d_req_valid && !ig;
         exp_ra = ig ? i_addr : (dg ? d_addr : 32'h0);
         checks++; if (i_req_ready !== ig || d_req_ready !== dg) begin errors++; $display("FAIL rnd_ready_%0d got i%b d%b want i%b d%b", c, i_req_ready, d_req_ready, ig, dg); end
         checks++; if (mem_ra !== exp_ra) begin errors++; $display("FAIL rnd_ra_%0d got %h want %h", c, mem_ra, exp_ra); end
         checks++; if (mem_we !== (dg && d_we) || mem_wa !== d_addr || mem_wd !== d_wdata) begin errors++; $display("FAIL rnd_wport_%0d got %b/%h/%h want %b/%h/%h", c, mem_we, mem_wa, mem_wd, dg && d_we, d_addr, d_wdata); end
         tick();
         checks++; if (i_rsp_valid !== m_irv || i_rsp_data !== m_ird) begin errors++; $display("FAIL rnd_irsp_%0d got %b/%h want %b/%h", c, i_rsp_valid, i_rsp_data, m_irv, m_ird); end
         checks++; if (d_rsp_valid !== m_drv || d_rsp_data !== m_drd) begin errors++; $display("FAIL rnd_drsp_%0d got %b/%h want %b/%h", c, d_rsp_valid, d_rsp_data, m_drv, m_drd); end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_ifetch();
      test_write_read();
      test_starvation();
      test_write_grant();
      test_reset_mid();
      test_burst_read();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
